// File: rtl/down_counter_pkg.sv
// Shared constants for the down counter block.
package down_counter_pkg;

  // Counter width used when the instantiating code does not override it.
  localparam int DEFAULT_WIDTH = 4;

  // Legal width range for the counter.
  localparam int MIN_WIDTH = 1;
  localparam int MAX_WIDTH = 32;

endpackage : down_counter_pkg

// File: rtl/down_counter_if.sv
// Interface carrying the count value from the counter to its consumers.
// The counter drives it through the master modport. Displays and other
// downstream logic observe it through the slave modport.
interface down_counter_if
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] counter;

  modport master (output counter);
  modport slave  (input  counter);

endinterface : down_counter_if

// File: rtl/down_counter.sv
// Free-running binary down counter.
// The count drops by one on every rising clock edge and wraps from zero
// to all-ones, so one full sequence lasts 2**WIDTH edges. An asynchronous
// active-high reset loads RESET_VALUE. That reset overrides the clock, even
// on the same edge. The output comes straight from the state register.
module down_counter
  import down_counter_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] counter
);

  // Wrap target after zero. It is all-ones no matter what RESET_VALUE is.
  localparam logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

  // Count state: reset loads RESET_VALUE; otherwise decrement with wrap to MAX_COUNT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter <= RESET_VALUE;
    end else if (counter == ZERO) begin
      counter <= MAX_COUNT;
    end else begin
      counter <= counter - ONE;
    end
  end

endmodule : down_counter

// File: tb/tb_down_counter.sv
// Directed bench for down_counter. It runs a default 4-bit instance and a
// 3-bit instance whose reset value is 5. Both are driven from one clock.
module tb_down_counter;

  logic clk;
  logic reset;
  logic reset3;

  int n_cmp;
  int n_err;

  down_counter_if #(.WIDTH(4)) cif  ();
  down_counter_if #(.WIDTH(3)) cif3 ();

  down_counter #(.WIDTH(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .counter (cif.counter)
  );

  down_counter #(.WIDTH(3), .RESET_VALUE(3'd5)) dut3 (
    .clk     (clk),
    .reset   (reset3),
    .counter (cif3.counter)
  );

  // 10 ns clock; rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to one time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Power-up reset: value is defined immediately, survives clock edges, and
  // the first edge after release gives RESET_VALUE-1.
  task automatic test_reset();
    #1;
    reset  = 1'b1;
    reset3 = 1'b1;
    #1; // t = 2, before any clock edge
    n_cmp++;
    if (cif.counter !== 4'd15) begin
      n_err++;
      $display("FAIL reset_immediate: got %0d expected 15", cif.counter);
    end
    n_cmp++;
    if (cif3.counter !== 3'd5) begin
      n_err++;
      $display("FAIL reset3_immediate: got %0d expected 5", cif3.counter);
    end
    #10; // t = 12, after the edge at 5 with reset still high
    n_cmp++;
    if (cif.counter !== 4'd15) begin
      n_err++;
      $display("FAIL reset_hold: got %0d expected 15", cif.counter);
    end
    #8; // t = 20
    reset = 1'b0;
    #2; // t = 22, released but no edge yet
    n_cmp++;
    if (cif.counter !== 4'd15) begin
      n_err++;
      $display("FAIL reset_release_hold: got %0d expected 15", cif.counter);
    end
    tick(); // edge at 25
    n_cmp++;
    if (cif.counter !== 4'd14) begin
      n_err++;
      $display("FAIL reset_first_edge: got %0d expected 14", cif.counter);
    end
  endtask

  // Free run from 14 for one full period of 16 edges, crossing the wrap.
  task automatic test_free_run();
    logic [3:0] seq [16] = '{4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8, 4'd7, 4'd6,
                             4'd5,  4'd4,  4'd3,  4'd2,  4'd1, 4'd0, 4'd15, 4'd14};
    for (int i = 0; i < 16; i++) begin
      tick();
      n_cmp++;
      if (cif.counter !== seq[i]) begin
        n_err++;
        $display("FAIL free_run[%0d]: got %0d expected %0d", i, cif.counter, seq[i]);
      end
    end
  endtask

  // Reset asserted between edges while the count is 7.
  task automatic test_async_mid();
    for (int i = 0; i < 7; i++) tick(); // 14 -> 7
    n_cmp++;
    if (cif.counter !== 4'd7) begin
      n_err++;
      $display("FAIL async_pre: got %0d expected 7", cif.counter);
    end
    #3;
    reset = 1'b1;
    #1; // still before the next rising edge
    n_cmp++;
    if (cif.counter !== 4'd15) begin
      n_err++;
      $display("FAIL async_immediate: got %0d expected 15", cif.counter);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (cif.counter !== 4'd15) begin
        n_err++;
        $display("FAIL async_hold[%0d]: got %0d expected 15", i, cif.counter);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (cif.counter !== 4'd15) begin
      n_err++;
      $display("FAIL async_release_hold: got %0d expected 15", cif.counter);
    end
    tick();
    n_cmp++;
    if (cif.counter !== 4'd14) begin
      n_err++;
      $display("FAIL async_first_edge: got %0d expected 14", cif.counter);
    end
  endtask

  // Reset rising at the same instant as a clock edge while the count is 3.
  task automatic test_coincident();
    for (int i = 0; i < 11; i++) tick(); // 14 -> 3
    n_cmp++;
    if (cif.counter !== 4'd3) begin
      n_err++;
      $display("FAIL coincident_pre: got %0d expected 3", cif.counter);
    end
    #9; // lands exactly on the next rising edge
    reset = 1'b1;
    #1;
    n_cmp++;
    if (cif.counter !== 4'd15) begin
      n_err++;
      $display("FAIL coincident: got %0d expected 15 (not 2)", cif.counter);
    end
    tick();
    n_cmp++;
    if (cif.counter !== 4'd15) begin
      n_err++;
      $display("FAIL coincident_hold: got %0d expected 15", cif.counter);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    n_cmp++;
    if (cif.counter !== 4'd14) begin
      n_err++;
      $display("FAIL coincident_first_edge: got %0d expected 14", cif.counter);
    end
  endtask

  // WIDTH=3, RESET_VALUE=5: sequence 5,4,3,2,1,0,7,6 from release.
  task automatic test_param();
    logic [2:0] seq3 [7] = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6};
    @(negedge clk);
    reset3 = 1'b0;
    #1;
    n_cmp++;
    if (cif3.counter !== 3'd5) begin
      n_err++;
      $display("FAIL param_release: got %0d expected 5", cif3.counter);
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      n_cmp++;
      if (cif3.counter !== seq3[i]) begin
        n_err++;
        $display("FAIL param[%0d]: got %0d expected %0d", i, cif3.counter, seq3[i]);
      end
    end
  endtask

  // 1000 edges against a modulo-2**WIDTH model for both instances.
  task automatic test_long_run();
    logic [3:0] exp4;
    logic [2:0] exp3;
    exp4 = 4'd14; // 4-bit count: 14 -> (7 edges) -> 7 after test_param
    exp3 = 3'd6;
    for (int i = 0; i < 7; i++) exp4 = exp4 - 4'd1;
    n_cmp++;
    if (cif.counter !== exp4) begin
      n_err++;
      $display("FAIL long_pre: got %0d expected %0d", cif.counter, exp4);
    end
    for (int i = 0; i < 1000; i++) begin
      tick();
      exp4 = exp4 - 4'd1;
      exp3 = exp3 - 3'd1;
      n_cmp++;
      if (cif.counter !== exp4) begin
        n_err++;
        $display("FAIL long4[%0d]: got %0d expected %0d", i, cif.counter, exp4);
      end
      n_cmp++;
      if (cif3.counter !== exp3) begin
        n_err++;
        $display("FAIL long3[%0d]: got %0d expected %0d", i, cif3.counter, exp3);
      end
    end
  endtask

  // Test sequence and summary.
  initial begin
    n_cmp  = 0;
    n_err  = 0;
    reset  = 1'b0;
    reset3 = 1'b0;
    test_reset();
    test_free_run();
    test_async_mid();
    test_coincident();
    test_param();
    test_long_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_down_counter
